// File: rtl/tm_pkg.sv
// ============================================================================
// Module      : tm_pkg
// Description : Shared types and constants for the telemetry frame formers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tm_pkg;

  typedef enum logic [1:0] {
    SLOT_SYNC = 2'd0,
    SLOT_CNT  = 2'd1,
    SLOT_DATA = 2'd2
  } slot_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_EMIT = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam logic [11:0] C_SYNC_WORD = 12'hF1A;
  localparam logic [11:0] C_FILL_WORD = 12'h000;

  // Fixed frame map: marker, frame counter, then data slots.
  function automatic slot_type_e slot_type_of(input int unsigned slot);
    if (slot == 0) begin
      return SLOT_SYNC;
    end else if (slot == 1) begin
      return SLOT_CNT;
    end
    return SLOT_DATA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tm_word_scheduler_if.sv
// ============================================================================
// Module      : tm_word_scheduler_if
// Description : Strobe, channel request/grant and word-stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tm_word_scheduler_if #(
  parameter int N_CH = 8,
  parameter int DW   = 12
);

  logic                 word_stb;
  logic [N_CH-1:0]      ch_req;
  logic [N_CH*DW-1:0]   ch_data;
  logic [N_CH-1:0]      ch_gnt;
  logic [DW-1:0]        word_out;
  logic                 word_vld;
  logic                 frame_start;
  logic [7:0]           frame_cnt;

  modport master (
    output word_stb, ch_req, ch_data,
    input  ch_gnt, word_out, word_vld, frame_start, frame_cnt
  );

  modport slave (
    input  word_stb, ch_req, ch_data,
    output ch_gnt, word_out, word_vld, frame_start, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/tm_word_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin find-first starting at a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_CH = 8,
  parameter int PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            found,
  output logic [PW-1:0]   next_ptr
);

  localparam logic [PW:0]   c_n_ch = (PW+1)'(N_CH);
  localparam logic [PW-1:0] c_last = PW'(N_CH - 1);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    next_ptr = ptr;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      // Candidate index ptr+i, folded back into 0..N_CH-1.
      w_sum = {1'b0, ptr} + (PW+1)'(i);
      if (w_sum >= c_n_ch) begin
        w_sum = w_sum - c_n_ch;
      end
      w_idx = w_sum[PW-1:0];
      if (!found && req[w_idx]) begin
        found        = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
        next_ptr     = (w_idx == c_last) ? '0 : w_idx + PW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tm_word_scheduler.sv
// ============================================================================
// Module      : tm_word_scheduler
// Description : Per-slot frame scheduler: sync, frame count, round-robin data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm_word_scheduler
  import tm_pkg::*;
#(
  parameter int             N_CH            = 8,
  parameter int             DW              = 12,
  parameter int             WORDS_PER_FRAME = 32,
  parameter logic [DW-1:0]  SYNC_WORD       = DW'(C_SYNC_WORD),
  parameter logic [DW-1:0]  FILL_WORD       = DW'(C_FILL_WORD)
) (
  input  logic               clk,
  input  logic               rst,
  tm_word_scheduler_if.slave bus
);

  localparam int            c_pw        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int            c_sw        = $clog2(WORDS_PER_FRAME);
  localparam logic [c_sw-1:0] c_last_slot = c_sw'(WORDS_PER_FRAME - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic [c_sw-1:0]   r_slot;
  slot_type_e        r_slot_type;
  logic [c_pw-1:0]   r_ptr;
  logic [DW-1:0]     r_word;
  logic [7:0]        r_frame_cnt;

  logic [N_CH-1:0]   w_gnt;
  logic [c_pw-1:0]   w_gnt_idx;
  logic              w_found;
  logic [c_pw-1:0]   w_next_ptr;
  logic [DW-1:0]     w_ch_data [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign w_ch_data[gi] = bus.ch_data[gi*DW +: DW];
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .PW   (c_pw)
  ) u_arb (
    .req      (bus.ch_req),
    .ptr      (r_ptr),
    .gnt      (w_gnt),
    .gnt_idx  (w_gnt_idx),
    .found    (w_found),
    .next_ptr (w_next_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobes seen in ARB or EMIT fall through without being accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (bus.word_stb) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      ST_ARB:  w_state_nxt = ST_EMIT;
      ST_EMIT: w_state_nxt = ST_WAIT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot      <= '0;
      r_slot_type <= SLOT_SYNC;
      r_ptr       <= '0;
      r_word      <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_slot_type <= slot_type_of(32'(r_slot));
        if (r_slot == c_last_slot) begin
          r_slot      <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_slot <= r_slot + c_sw'(1);
        end
      end
      if (r_state == ST_ARB) begin
        case (r_slot_type)
          SLOT_SYNC: r_word <= SYNC_WORD;
          SLOT_CNT:  r_word <= DW'(r_frame_cnt);
          default: begin
            if (w_found) begin
              r_word <= w_ch_data[w_gnt_idx];
              r_ptr  <= w_next_ptr;
            end else begin
              r_word <= FILL_WORD;
            end
          end
        endcase
      end
    end
  end

  assign bus.ch_gnt      = (r_state == ST_ARB && r_slot_type == SLOT_DATA) ? w_gnt : '0;
  assign bus.word_out    = r_word;
  assign bus.word_vld    = (r_state == ST_EMIT);
  assign bus.frame_start = (r_state == ST_EMIT) && (r_slot_type == SLOT_SYNC);
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tm_word_scheduler.sv
// ============================================================================
// Module      : tb_tm_word_scheduler
// Description : Directed self-checking bench for the frame word scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tm_word_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tm_word_scheduler_if #(.N_CH(8), .DW(12)) bus ();

  tm_word_scheduler #(
    .N_CH            (8),
    .DW              (12),
    .WORDS_PER_FRAME (32),
    .SYNC_WORD       (12'hF1A),
    .FILL_WORD       (12'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word slot: strobe, ARB (grant sampled), EMIT (word sampled), WAIT.
  task automatic do_slot(input logic [7:0] req, input bit extra, input logic [11:0] exp_word,
                         input bit exp_fs, input logic [7:0] exp_gnt, input string tag);
    @(posedge clk); #1;
    bus.word_stb = 1'b1;
    bus.ch_req   = req;
    @(posedge clk); #1;
    if (!extra) bus.word_stb = 1'b0;
    chk({tag, " gnt"}, 32'(bus.ch_gnt), 32'(exp_gnt));
    chk({tag, " vld_arb"}, 32'(bus.word_vld), 32'd0);
    @(posedge clk); #1;
    bus.word_stb = 1'b0;
    chk({tag, " vld"}, 32'(bus.word_vld), 32'd1);
    chk({tag, " word"}, 32'(bus.word_out), 32'(exp_word));
    chk({tag, " fs"}, 32'(bus.frame_start), 32'(exp_fs));
    @(posedge clk); #1;
    chk({tag, " vld_wait"}, 32'(bus.word_vld), 32'd0);
    chk({tag, " hold"}, 32'(bus.word_out), 32'(exp_word));
  endtask

  logic [7:0] f3_req [10];
  int         f3_ch  [10];
  int         ch;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.word_stb = 1'b0;
    bus.ch_req   = 8'hFF;
    for (int i = 0; i < 8; i++) bus.ch_data[i*12 +: 12] = 12'(12'h100 + i);
    f3_req = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h48, 8'h48, 8'h48, 8'hFF};
    f3_ch  = '{6, 7, 0, 1, 2, 3, 6, 3, 6, 7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst vld", 32'(bus.word_vld), 32'd0);
    chk("rst word", 32'(bus.word_out), 32'd0);
    chk("rst fs", 32'(bus.frame_start), 32'd0);
    chk("rst fcnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst gnt", 32'(bus.ch_gnt), 32'd0);
    rst = 1'b1;

    // Frame 0: nobody requesting
    for (int s = 0; s < 32; s++) begin
      if (s == 0) do_slot(8'h00, 1'b0, 12'hF1A, 1'b1, 8'h00, "f0 sync");
      else        do_slot(8'h00, 1'b0, 12'h000, 1'b0, 8'h00, "f0 slot");
    end
    chk("f0 fcnt", 32'(bus.frame_cnt), 32'd1);

    // Frame 1: all channels requesting, rotation 0..7
    for (int s = 0; s < 32; s++) begin
      if (s == 0)      do_slot(8'hFF, 1'b0, 12'hF1A, 1'b1, 8'h00, "f1 sync");
      else if (s == 1) do_slot(8'hFF, 1'b0, 12'h001, 1'b0, 8'h00, "f1 cnt");
      else begin
        ch = (s - 2) % 8;
        do_slot(8'hFF, 1'b0, 12'(12'h100 + ch), 1'b0, 8'(1 << ch), "f1 data");
      end
    end
    chk("f1 fcnt", 32'(bus.frame_cnt), 32'd2);

    // Frame 2: walk pointer to 4, then only channels 3 and 6
    for (int s = 0; s < 32; s++) begin
      if (s == 0)      do_slot(8'h00, 1'b0, 12'hF1A, 1'b1, 8'h00, "f2 sync");
      else if (s == 1) do_slot(8'h00, 1'b0, 12'h002, 1'b0, 8'h00, "f2 cnt");
      else if (s < 12) do_slot(f3_req[s-2], 1'b0, 12'(12'h100 + f3_ch[s-2]), 1'b0,
                               8'(1 << f3_ch[s-2]), "f2 rr");
      else             do_slot(8'h00, 1'b0, 12'h000, 1'b0, 8'h00, "f2 fill");
    end

    // Frame 3: extra strobe during ARB on slots 5 and 31
    for (int s = 0; s < 32; s++) begin
      if (s == 0)      do_slot(8'h00, 1'b0, 12'hF1A, 1'b1, 8'h00, "f3 sync");
      else if (s == 1) do_slot(8'h00, 1'b0, 12'h003, 1'b0, 8'h00, "f3 cnt");
      else             do_slot(8'h00, (s == 5 || s == 31), 12'h000, 1'b0, 8'h00, "f3 slot");
    end
    chk("f3 fcnt", 32'(bus.frame_cnt), 32'd4);

    // Frame 4: data up to slot 16, reset during slot 17
    for (int s = 0; s < 17; s++) begin
      if (s == 0)      do_slot(8'hFF, 1'b0, 12'hF1A, 1'b1, 8'h00, "f4 sync");
      else if (s == 1) do_slot(8'hFF, 1'b0, 12'h004, 1'b0, 8'h00, "f4 cnt");
      else begin
        ch = (s - 2) % 8;
        do_slot(8'hFF, 1'b0, 12'(12'h100 + ch), 1'b0, 8'(1 << ch), "f4 data");
      end
    end
    @(posedge clk); #1;
    bus.word_stb = 1'b1;
    @(posedge clk); #1;
    bus.word_stb = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid-rst vld", 32'(bus.word_vld), 32'd0);
    chk("mid-rst word", 32'(bus.word_out), 32'd0);
    chk("mid-rst fs", 32'(bus.frame_start), 32'd0);
    chk("mid-rst fcnt", 32'(bus.frame_cnt), 32'd0);
    chk("mid-rst gnt", 32'(bus.ch_gnt), 32'd0);

    // Restarted frame: pointer back at 0
    for (int s = 0; s < 32; s++) begin
      if (s == 0)      do_slot(8'h00, 1'b0, 12'hF1A, 1'b1, 8'h00, "r0 sync");
      else if (s == 1) do_slot(8'h00, 1'b0, 12'h000, 1'b0, 8'h00, "r0 cnt");
      else if (s == 2) do_slot(8'hFF, 1'b0, 12'h100, 1'b0, 8'h01, "r0 ptr");
      else             do_slot(8'h00, 1'b0, 12'h000, 1'b0, 8'h00, "r0 fill");
    end
    chk("r0 fcnt", 32'(bus.frame_cnt), 32'd1);

    // Frames 1..255 after reset, then the wrapped frame 256
    for (int f = 1; f < 257; f++) begin
      for (int s = 0; s < 32; s++) begin
        if (s == 0)      do_slot(8'h00, 1'b0, 12'hF1A, 1'b1, 8'h00, "wrap sync");
        else if (s == 1) do_slot(8'h00, 1'b0, 12'(f % 256), 1'b0, 8'h00, "wrap cnt");
        else             do_slot(8'h00, 1'b0, 12'h000, 1'b0, 8'h00, "wrap fill");
      end
      if (f == 255) chk("wrap fcnt 255->0", 32'(bus.frame_cnt), 32'd0);
    end
    chk("wrap fcnt end", 32'(bus.frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
